// File: rtl/raycast_pkg.sv
// Shared raycaster constants: screen geometry, palette, sequencer states.
// Used by the slice calculator, the renderer and the VGA top level.
package raycast_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int CALC_TIMEOUT = 1023;

  localparam logic [2:0] CEIL_COLOUR  = 3'b001;
  localparam logic [2:0] WALL_COLOUR  = 3'b111;
  localparam logic [2:0] FLOOR_COLOUR = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LATCH,
    S_SETUP,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic logic [6:0] clamp_h(
    input logic [6:0] s,
    input logic [6:0] hmax
  );
    return (s > hmax) ? hmax : s;
  endfunction

endpackage

// File: rtl/slice_column_painter.sv
// Paints one column: y counter, ceiling/wall/floor split, colour mux.
// Pixel outputs are registered; plot is high for exactly SCREEN_H cycles.
module slice_column_painter
  import raycast_pkg::*;
#(
  parameter int         SCREEN_H     = raycast_pkg::SCREEN_H,
  parameter logic [2:0] CEIL_COLOUR  = raycast_pkg::CEIL_COLOUR,
  parameter logic [2:0] WALL_COLOUR  = raycast_pkg::WALL_COLOUR,
  parameter logic [2:0] FLOOR_COLOUR = raycast_pkg::FLOOR_COLOUR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] h,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  logic [7:0] top;
  logic [7:0] bottom;
  logic [6:0] y_nxt;
  logic [2:0] col_nxt;

  // Wall band bounds and colour of the row about to be emitted.
  always_comb begin
    top     = (8'(SCREEN_H) - {1'b0, h}) >> 1;
    bottom  = top + {1'b0, h};
    y_nxt   = start ? 7'd0 : y + 7'd1;
    col_nxt = FLOOR_COLOUR;
    if ({1'b0, y_nxt} < top) begin
      col_nxt = CEIL_COLOUR;
    end else if ({1'b0, y_nxt} < bottom) begin
      col_nxt = WALL_COLOUR;
    end
    done = plot && (y == 7'(SCREEN_H - 1));
  end

  // Row sequencer: start loads row 0, then one row per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (start) begin
      y      <= y_nxt;
      colour <= col_nxt;
      plot   <= 1'b1;
    end else if (plot) begin
      if (done) begin
        y      <= '0;
        colour <= '0;
        plot   <= 1'b0;
      end else begin
        y      <= y_nxt;
        colour <= col_nxt;
      end
    end
  end

endmodule

// File: rtl/column_slice_renderer.sv
// Frame sequencer: per column, request a slice height, then paint it.
// Owns the FSM, column counter and calculator timeout.
module column_slice_renderer
  import raycast_pkg::*;
#(
  parameter int         SCREEN_W     = raycast_pkg::SCREEN_W,
  parameter int         SCREEN_H     = raycast_pkg::SCREEN_H,
  parameter int         CALC_TIMEOUT = raycast_pkg::CALC_TIMEOUT,
  parameter logic [2:0] CEIL_COLOUR  = raycast_pkg::CEIL_COLOUR,
  parameter logic [2:0] WALL_COLOUR  = raycast_pkg::WALL_COLOUR,
  parameter logic [2:0] FLOOR_COLOUR = raycast_pkg::FLOOR_COLOUR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_frame,
  input  logic       end_calc,
  input  logic [6:0] slice_size,
  output logic       begin_calc,
  output logic [7:0] column_count,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  localparam int TW = $clog2(CALC_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(CALC_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    col;
  logic [TW-1:0] tcnt;
  logic          timed_out;
  logic [6:0]    h_reg;
  logic          paint_start;
  logic          paint_done;
  logic          last_col;
  logic          wait_expired;

  assign last_col     = (col == 8'(SCREEN_W - 1));
  assign wait_expired = (tcnt == TLAST);
  assign column_count = col;
  assign x            = col;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt   = state;
    begin_calc  = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    paint_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_frame) state_nxt = S_REQ;
      end
      S_REQ: begin
        begin_calc = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (end_calc || wait_expired) state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = S_SETUP;
      S_SETUP: begin
        paint_start = 1'b1;
        state_nxt   = S_DRAW;
      end
      S_DRAW: begin
        if (paint_done) state_nxt = S_NEXT;
      end
      S_NEXT: state_nxt = last_col ? S_DONE : S_REQ;
      S_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Column counter, calculator timeout and height capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      col       <= '0;
      tcnt      <= '0;
      timed_out <= 1'b0;
      h_reg     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_frame) col <= '0;
        end
        S_REQ: begin
          tcnt      <= '0;
          timed_out <= 1'b0;
        end
        S_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (!end_calc && wait_expired) timed_out <= 1'b1;
        end
        S_LATCH: begin
          h_reg <= timed_out ? 7'd0
                             : clamp_h(slice_size, 7'(SCREEN_H));
        end
        S_NEXT: begin
          if (!last_col) col <= col + 8'd1;
        end
        default: ;
      endcase
    end
  end

  slice_column_painter #(
    .SCREEN_H    (SCREEN_H),
    .CEIL_COLOUR (CEIL_COLOUR),
    .WALL_COLOUR (WALL_COLOUR),
    .FLOOR_COLOUR(FLOOR_COLOUR)
  ) u_painter (
    .clock (clock),
    .reset (reset),
    .start (paint_start),
    .h     (h_reg),
    .y     (y),
    .colour(colour),
    .plot  (plot),
    .done  (paint_done)
  );

endmodule

// File: tb/tb_column_slice_renderer.sv
// Bench for column_slice_renderer: calculator model, pixel scoreboard,
// per-frame colour totals, timeout, mid-frame reset and restart.
module tb_column_slice_renderer;
  import raycast_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_frame = 1'b0;
  logic       end_calc = 1'b0;
  logic [6:0] slice_size = 7'd99;
  logic       begin_calc;
  logic [7:0] column_count;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  int skip_col = 255;
  int mixed = 0;
  int stray = 0;

  int exp_col = 0;
  int exp_row = 0;
  int n_plot = 0;
  int n_ceil = 0;
  int n_wall = 0;
  int n_floor = 0;
  int n_done = 0;
  int frame_open = 0;

  always #5 clock = ~clock;

  column_slice_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .start_frame (start_frame),
    .end_calc    (end_calc),
    .slice_size  (slice_size),
    .begin_calc  (begin_calc),
    .column_count(column_count),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  task automatic chk(input string n, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0d, want %0d", n, got, want);
    end
  endtask

  function automatic int ret_of(input int c);
    if (mixed == 0) return 40;
    case (c % 4)
      0: return 40;
      1: return 127;
      2: return 0;
      default: return 41;
    endcase
  endfunction

  function automatic int h_of(input int c);
    int r;
    if (c == skip_col) return 0;
    r = ret_of(c);
    return (r > SCREEN_H) ? SCREEN_H : r;
  endfunction

  function automatic int colour_of(input int h, input int row);
    int top;
    top = (SCREEN_H - h) / 2;
    if (row < top) return int'(CEIL_COLOUR);
    if (row < top + h) return int'(WALL_COLOUR);
    return int'(FLOOR_COLOUR);
  endfunction

  // Slice calculator: end_calc 3 cycles after the request, result one
  // cycle later, garbage on slice_size otherwise.
  initial begin
    forever begin
      @(negedge clock);
      if (begin_calc && !reset && int'(column_count) != skip_col) begin
        repeat (3) @(negedge clock);
        end_calc = 1'b1;
        @(negedge clock);
        end_calc = 1'b0;
        slice_size = 7'(ret_of(int'(column_count)));
        @(negedge clock);
        slice_size = 7'd99;
        if (stray != 0) begin
          repeat (4) @(negedge clock);
          end_calc = 1'b1;
          @(negedge clock);
          end_calc = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every plot cycle is checked against the model.
  initial begin
    int cyc;
    int bc_cyc;
    int last_plot;
    logic bc_prev;
    cyc = 0;
    bc_cyc = 0;
    last_plot = 0;
    bc_prev = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        exp_col = 0; exp_row = 0; n_plot = 0; n_done = 0;
        n_ceil = 0; n_wall = 0; n_floor = 0; frame_open = 0;
      end else begin
        if (begin_calc) begin
          chk("begin_calc_one_cycle", int'(bc_prev), 0);
          if (frame_open == 0 && column_count == 8'd0) begin
            exp_col = 0; exp_row = 0; n_plot = 0; n_done = 0;
            n_ceil = 0; n_wall = 0; n_floor = 0; frame_open = 1;
          end else begin
            chk("req_column", int'(column_count), exp_col);
          end
          bc_cyc = cyc;
        end
        if (plot) begin
          if (exp_row == 0)
            chk("draw_latency", cyc - bc_cyc,
                (exp_col == skip_col) ? CALC_TIMEOUT + 3 : 6);
          chk("x", int'(x), exp_col);
          chk("column_count", int'(column_count), exp_col);
          chk("y", int'(y), exp_row);
          chk("colour", int'(colour), colour_of(h_of(exp_col), exp_row));
          chk("busy_while_plot", int'(busy), 1);
          n_plot++;
          if (colour == CEIL_COLOUR) n_ceil++;
          if (colour == WALL_COLOUR) n_wall++;
          if (colour == FLOOR_COLOUR) n_floor++;
          last_plot = cyc;
          exp_row++;
          if (exp_row == SCREEN_H) begin
            exp_row = 0;
            exp_col++;
          end
        end
        if (frame_done) begin
          chk("done_after_last_col", exp_col, SCREEN_W);
          chk("done_latency", cyc - last_plot, 2);
          chk("busy_at_done", int'(busy), 0);
          n_done++;
          frame_open = 0;
        end
      end
      bc_prev = begin_calc;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_begin_calc"}, int'(begin_calc), 0);
    chk({tag, "_column_count"}, int'(column_count), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_colour"}, int'(colour), 0);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic start_pulse();
    start_frame = 1'b1;
    @(negedge clock);
    start_frame = 1'b0;
    chk("start_begin_calc", int'(begin_calc), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_column", int'(column_count), 0);
  endtask

  task automatic wait_done(input int mid);
    int ok;
    ok = 0;
    for (int i = 0; i < 25000; i++) begin
      @(negedge clock);
      start_frame = (mid != 0 && plot && column_count == 8'd10 && y == 7'd0);
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
    start_frame = 1'b0;
    chk("frame_done_in_bound", ok, 1);
  endtask

  initial begin
    int found;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Mixed heights 40/127/0/41, column 5 times out, stray end_calc,
    // second start_frame mid-frame.
    mixed = 1; skip_col = 5; stray = 1;
    start_pulse();
    wait_done(1);
    @(negedge clock);
    chk("A_plots", n_plot, 19200);
    chk("A_wall", n_wall, 7920);
    chk("A_ceil", n_ceil, 5620);
    chk("A_floor", n_floor, 5660);
    chk("A_done_count", n_done, 1);

    // Back-to-back start, reset at column 80 row 50.
    mixed = 0; skip_col = 255; stray = 0;
    start_pulse();
    found = 0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clock);
      if (plot && column_count == 8'd80 && y == 7'd50) begin
        found = 1;
        break;
      end
    end
    chk("reached_col80_row50", found, 1);
    reset = 1'b1;
    @(negedge clock);
    check_zero("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Clean frame, every column height 40.
    start_pulse();
    wait_done(0);
    @(negedge clock);
    chk("C_plots", n_plot, 19200);
    chk("C_wall", n_wall, 6400);
    chk("C_ceil", n_ceil, 6400);
    chk("C_floor", n_floor, 6400);
    chk("C_done_count", n_done, 1);
    chk("C_idle_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
